// File: rtl/hazard_fwd_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_unit_if
//  Description : Pipeline-side bundle of the hazard/forwarding unit: ID-stage
//                operands, in-flight destinations and the bypass/stall outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_fwd_unit_if #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16
) ();
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic [NUM_SRC-1:0]        id_rs_used;
    logic [REG_AW-1:0]         id_rd;
    logic                      id_is_mc;
    logic [REG_AW-1:0]         ex_rd;
    logic                      ex_wb;
    logic                      ex_is_load;
    logic [REG_AW-1:0]         exmem_rd;
    logic                      exmem_wb;
    logic [REG_AW-1:0]         memwb_rd;
    logic                      memwb_wb;
    logic [2*NUM_SRC-1:0]      fwd_sel;
    logic                      stall;
    logic                      mc_busy;
    logic                      mc_done;
    logic [REG_AW-1:0]         mc_rd;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_is_mc,
        output ex_rd, ex_wb, ex_is_load, exmem_rd, exmem_wb, memwb_rd, memwb_wb,
        input  fwd_sel, stall, mc_busy, mc_done, mc_rd, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_is_mc,
        input  ex_rd, ex_wb, ex_is_load, exmem_rd, exmem_wb, memwb_rd, memwb_wb,
        output fwd_sel, stall, mc_busy, mc_done, mc_rd, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_unit
//  Description : Operand bypass selection, load-use / multicycle stall logic,
//                one-entry multicycle latency scoreboard and stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int MC_LAT  = 4,
    parameter int CNT_W   = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    hazard_fwd_unit_if.slave pipe
);
    localparam int                c_cw  = $clog2(MC_LAT + 1);
    localparam logic [c_cw-1:0]   c_lat = c_cw'(MC_LAT);
    localparam logic [c_cw-1:0]   c_one = c_cw'(1);
    localparam logic [c_cw-1:0]   c_two = c_cw'(2);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_cw-1:0]     r_cnt;
    logic [REG_AW-1:0]   r_mc_rd;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic [NUM_SRC-1:0]   w_m_ex;
    logic [NUM_SRC-1:0]   w_m_exmem;
    logic [NUM_SRC-1:0]   w_m_memwb;
    logic [NUM_SRC-1:0]   w_mc_dep;
    logic [2*NUM_SRC-1:0] w_fwd_sel;
    logic                 w_load_use;
    logic                 w_mc_raw;
    logic                 w_mc_struct;
    logic                 w_mc_waw;
    logic                 w_stall;
    logic                 w_issue;

    // Per-source comparators; register x0 is hard-wired and never matches.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_AW-1:0] w_rs;
            logic              w_rd_ok;
            assign w_rs    = pipe.id_rs[gi*REG_AW +: REG_AW];
            assign w_rd_ok = pipe.id_rs_used[gi] && (w_rs != '0);

            assign w_m_ex[gi]    = w_rd_ok && pipe.ex_wb    && (pipe.ex_rd    == w_rs);
            assign w_m_exmem[gi] = w_rd_ok && pipe.exmem_wb && (pipe.exmem_rd == w_rs);
            assign w_m_memwb[gi] = w_rd_ok && pipe.memwb_wb && (pipe.memwb_rd == w_rs);
            assign w_mc_dep[gi]  = w_rd_ok && (r_mc_rd == w_rs);

            assign w_fwd_sel[2*gi +: 2] = w_m_exmem[gi] ? 2'b10 :
                                          w_m_memwb[gi] ? 2'b01 : 2'b00;
        end
    endgenerate

    assign w_load_use  = pipe.id_valid && pipe.ex_is_load && (|w_m_ex);
    assign w_mc_raw    = pipe.id_valid && r_busy && (|w_mc_dep);
    assign w_mc_struct = pipe.id_valid && r_busy && pipe.id_is_mc;
    assign w_mc_waw    = pipe.id_valid && r_busy &&
                         (pipe.id_rd == r_mc_rd) && (pipe.id_rd != '0);
    assign w_stall     = w_load_use || w_mc_raw || w_mc_struct || w_mc_waw;
    assign w_issue     = pipe.id_valid && pipe.id_is_mc && !w_stall;

    // Busy/done are registered alongside the count so they stay glitch-free;
    // done is raised for the cycle in which the count reads one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mc_rd <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state <= S_BUSY;
                        r_cnt   <= c_lat;
                        r_mc_rd <= pipe.id_rd;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_cnt  <= r_cnt - c_one;
                    r_done <= (r_cnt == c_two);
                    if (r_cnt == c_one) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign pipe.fwd_sel   = w_fwd_sel;
    assign pipe.stall     = w_stall;
    assign pipe.mc_busy   = r_busy;
    assign pipe.mc_done   = r_done;
    assign pipe.mc_rd     = r_mc_rd;
    assign pipe.stall_cnt = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_fwd_unit
//  Description : Directed scoreboard bench; a second instance with a 4-bit
//                counter shares the same stimulus to exercise saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_unit;
    logic clk;
    logic rst;

    hazard_fwd_unit_if #(.NUM_SRC(2), .REG_AW(5), .CNT_W(16)) bus_a ();
    hazard_fwd_unit_if #(.NUM_SRC(2), .REG_AW(5), .CNT_W(4))  bus_b ();

    hazard_fwd_unit #(.NUM_SRC(2), .REG_AW(5), .MC_LAT(4), .CNT_W(16)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .pipe (bus_a)
    );

    hazard_fwd_unit #(.NUM_SRC(2), .REG_AW(5), .MC_LAT(4), .CNT_W(4)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .pipe (bus_b)
    );

    assign bus_b.id_valid   = bus_a.id_valid;
    assign bus_b.id_rs      = bus_a.id_rs;
    assign bus_b.id_rs_used = bus_a.id_rs_used;
    assign bus_b.id_rd      = bus_a.id_rd;
    assign bus_b.id_is_mc   = bus_a.id_is_mc;
    assign bus_b.ex_rd      = bus_a.ex_rd;
    assign bus_b.ex_wb      = bus_a.ex_wb;
    assign bus_b.ex_is_load = bus_a.ex_is_load;
    assign bus_b.exmem_rd   = bus_a.exmem_rd;
    assign bus_b.exmem_wb   = bus_a.exmem_wb;
    assign bus_b.memwb_rd   = bus_a.memwb_rd;
    assign bus_b.memwb_wb   = bus_a.memwb_wb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [3:0]  fwd;
        logic        stall;
        logic        busy;
        logic        done;
        logic [4:0]  rd;
        int          scnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic clear_in();
        bus_a.id_valid   = 1'b0;
        bus_a.id_rs      = '0;
        bus_a.id_rs_used = '0;
        bus_a.id_rd      = '0;
        bus_a.id_is_mc   = 1'b0;
        bus_a.ex_rd      = '0;
        bus_a.ex_wb      = 1'b0;
        bus_a.ex_is_load = 1'b0;
        bus_a.exmem_rd   = '0;
        bus_a.exmem_wb   = 1'b0;
        bus_a.memwb_rd   = '0;
        bus_a.memwb_wb   = 1'b0;
    endtask

    // Inputs are applied 1 time unit after a rising edge; outputs are
    // compared on the following falling edge.
    task automatic step(input string tag, input logic [3:0] fwd, input logic st,
                        input logic bz, input logic dn, input logic [4:0] rd);
        exp_t e;
        int   sat;
        e.tag = tag; e.fwd = fwd; e.stall = st; e.busy = bz; e.done = dn;
        e.rd = rd; e.scnt = model_cnt;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        sat = (e.scnt > 15) ? 15 : e.scnt;
        chk({e.tag, ".fwd_sel"},   32'(bus_a.fwd_sel),   32'(e.fwd));
        chk({e.tag, ".stall"},     32'(bus_a.stall),     32'(e.stall));
        chk({e.tag, ".mc_busy"},   32'(bus_a.mc_busy),   32'(e.busy));
        chk({e.tag, ".mc_done"},   32'(bus_a.mc_done),   32'(e.done));
        chk({e.tag, ".mc_rd"},     32'(bus_a.mc_rd),     32'(e.rd));
        chk({e.tag, ".stall_cnt"}, 32'(bus_a.stall_cnt), 32'(e.scnt));
        chk({e.tag, ".sat_cnt"},   32'(bus_b.stall_cnt), 32'(sat));
        @(posedge clk);
        if (rst) model_cnt = 0;
        else if (e.stall) model_cnt++;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_in();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_cnt = 0;
        step("reset_state", 4'b0000, 0, 0, 0, 5'd0);

        // Bypass priority and x0 exclusion
        bus_a.exmem_rd = 5; bus_a.exmem_wb = 1; bus_a.memwb_rd = 5; bus_a.memwb_wb = 1;
        bus_a.id_rs = {5'd0, 5'd5}; bus_a.id_rs_used = 2'b01;
        step("fwd_exmem", 4'b0010, 0, 0, 0, 5'd0);
        bus_a.exmem_wb = 0;
        step("fwd_memwb", 4'b0001, 0, 0, 0, 5'd0);
        bus_a.id_rs = {5'd0, 5'd0}; bus_a.exmem_rd = 0; bus_a.exmem_wb = 1; bus_a.memwb_rd = 0;
        step("fwd_x0", 4'b0000, 0, 0, 0, 5'd0);
        bus_a.id_rs = {5'd6, 5'd5}; bus_a.id_rs_used = 2'b11;
        bus_a.exmem_rd = 5; bus_a.memwb_rd = 6;
        step("fwd_both", 4'b0110, 0, 0, 0, 5'd0);
        bus_a.exmem_rd = 6;
        step("fwd_prio_src1", 4'b1000, 0, 0, 0, 5'd0);

        // Load-use
        clear_in();
        bus_a.id_valid = 1; bus_a.ex_is_load = 1; bus_a.ex_rd = 7; bus_a.ex_wb = 1;
        bus_a.id_rs = {5'd7, 5'd0}; bus_a.id_rs_used = 2'b10;
        step("lu_stall", 4'b0000, 1, 0, 0, 5'd0);
        clear_in();
        bus_a.id_valid = 1; bus_a.exmem_rd = 7; bus_a.exmem_wb = 1;
        bus_a.id_rs = {5'd7, 5'd0}; bus_a.id_rs_used = 2'b10;
        step("lu_resolved", 4'b1000, 0, 0, 0, 5'd0);
        clear_in();
        bus_a.id_valid = 1; bus_a.ex_is_load = 1; bus_a.ex_rd = 7; bus_a.ex_wb = 1;
        bus_a.id_rs = {5'd7, 5'd0}; bus_a.id_rs_used = 2'b00;
        step("lu_unused", 4'b0000, 0, 0, 0, 5'd0);

        // Multicycle issue followed by a dependent reader of x9
        clear_in();
        bus_a.id_valid = 1; bus_a.id_is_mc = 1; bus_a.id_rd = 9;
        step("mc_issue", 4'b0000, 0, 0, 0, 5'd0);
        clear_in();
        bus_a.id_valid = 1; bus_a.id_rs = {5'd0, 5'd9}; bus_a.id_rs_used = 2'b01; bus_a.id_rd = 10;
        step("mc_dep1", 4'b0000, 1, 1, 0, 5'd9);
        step("mc_dep2", 4'b0000, 1, 1, 0, 5'd9);
        step("mc_dep3", 4'b0000, 1, 1, 0, 5'd9);
        step("mc_dep4", 4'b0000, 1, 1, 1, 5'd9);
        step("mc_release", 4'b0000, 0, 0, 0, 5'd9);

        // Back-to-back multicycle ops
        clear_in();
        bus_a.id_valid = 1; bus_a.id_is_mc = 1; bus_a.id_rd = 11;
        step("b2b_first", 4'b0000, 0, 0, 0, 5'd9);
        bus_a.id_rd = 12;
        step("b2b_wait1", 4'b0000, 1, 1, 0, 5'd11);
        step("b2b_wait2", 4'b0000, 1, 1, 0, 5'd11);
        step("b2b_wait3", 4'b0000, 1, 1, 0, 5'd11);
        step("b2b_wait4", 4'b0000, 1, 1, 1, 5'd11);
        step("b2b_issue", 4'b0000, 0, 0, 0, 5'd11);

        // WAW against the outstanding destination, then reset mid-operation
        clear_in();
        bus_a.id_valid = 1; bus_a.id_rd = 12;
        step("waw", 4'b0000, 1, 1, 0, 5'd12);
        clear_in();
        step("mc_cnt3", 4'b0000, 0, 1, 0, 5'd12);
        rst = 1'b1;
        step("rst_at_cnt2", 4'b0000, 0, 1, 0, 5'd12);
        rst = 1'b0;
        step("rst_after", 4'b0000, 0, 0, 0, 5'd0);
        step("rst_no_done1", 4'b0000, 0, 0, 0, 5'd0);
        step("rst_no_done2", 4'b0000, 0, 0, 0, 5'd0);

        // Sustained stall: 4-bit counter must stop at 15
        bus_a.id_valid = 1; bus_a.ex_is_load = 1; bus_a.ex_rd = 7; bus_a.ex_wb = 1;
        bus_a.id_rs = {5'd7, 5'd0}; bus_a.id_rs_used = 2'b10;
        for (int k = 0; k < 20; k++) begin
            step("sat_stall", 4'b0000, 1, 0, 0, 5'd0);
        end
        clear_in();
        step("sat_end", 4'b0000, 0, 0, 0, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
